// File: rtl/mitll_sfq_pkg.sv
// Shared constants and helpers for the toggle-encoded SFQ behavioural blocks.
package mitll_sfq_pkg;

    localparam int MAX_CH    = 32;
    localparam int MAX_DELAY = 7;
    localparam int TMR_W     = 3;

    // One SFQ pulse is any level change between consecutive samples.
    function automatic logic tog_detect(
        input logic cur,
        input logic prev
    );
        return cur ^ prev;
    endfunction

endpackage

// File: rtl/sfq_tog_pipe.sv
// DELAY-deep read-mask pipeline feeding a toggle-encoded output register.
// DELAY=0 toggles the output on the same edge the mask is presented.
module sfq_tog_pipe
    import mitll_sfq_pkg::*;
#(
    parameter int CH    = 4,
    parameter int DELAY = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CH-1:0] mask_i,
    output logic [CH-1:0] out_o
);

    logic [CH-1:0] out_q;
    logic [CH-1:0] out_d;

    generate
        if (DELAY == 0) begin : g_bypass
            assign out_d = out_q ^ mask_i;
        end else begin : g_pipe
            logic [CH-1:0] pipe_q [DELAY];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DELAY; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= mask_i;
                    for (int i = 1; i < DELAY; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign out_d = out_q ^ pipe_q[DELAY-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/mitll_ndro_bank.sv
// CH-channel NDRO bank with a shared toggle-encoded read strobe.
// Define NDRO_VIOL_CHECK_EN to build the hold timer and violation monitor.
module mitll_ndro_bank
    import mitll_sfq_pkg::*;
#(
    parameter int CH    = 4,
    parameter int DELAY = 2,
    parameter int HOLD  = 1,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CH-1:0]    set,
    input  logic [CH-1:0]    reset,
    input  logic             rd,
    input  logic             viol_clr,
    output logic [CH-1:0]    out,
    output logic [CH-1:0]    state,
    output logic [CH-1:0]    viol,
    output logic [ERR_W-1:0] viol_cnt
);

    logic [CH-1:0] set_q;
    logic [CH-1:0] reset_q;
    logic          rd_q;
    logic [CH-1:0] state_q;
    logic [CH-1:0] state_d;

    logic [CH-1:0] set_p;
    logic [CH-1:0] reset_p;
    logic          rd_p;
    logic [CH-1:0] mask;

    generate
        for (genvar i = 0; i < CH; i++) begin : g_det
            assign set_p[i]   = tog_detect(set[i], set_q[i]);
            assign reset_p[i] = tog_detect(reset[i], reset_q[i]);
        end
    endgenerate

    assign rd_p = tog_detect(rd, rd_q);

    // Reset wins over set; the read captures the pre-update value.
    assign state_d = (state_q | set_p) & ~reset_p;
    assign mask    = rd_p ? state_q : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            set_q   <= '0;
            reset_q <= '0;
            rd_q    <= 1'b0;
            state_q <= '0;
        end else begin
            set_q   <= set;
            reset_q <= reset;
            rd_q    <= rd;
            state_q <= state_d;
        end
    end

    assign state = state_q;

    sfq_tog_pipe #(
        .CH    (CH),
        .DELAY (DELAY)
    ) u_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .mask_i  (mask),
        .out_o   (out)
    );

`ifdef NDRO_VIOL_CHECK_EN
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic [CH-1:0]    viol_q;
    logic [CH-1:0]    viol_d;
    logic [ERR_W-1:0] cnt_q;
    logic [ERR_W-1:0] cnt_d;
    logic [CH-1:0]    new_v;
    logic             busy;

    assign busy  = rd_p | (tmr_q != '0);
    assign new_v = (set_p & reset_p) | ((set_p | reset_p) & {CH{busy}});

    always_comb begin
        tmr_d = tmr_q;
        if (rd_p) begin
            tmr_d = TMR_W'(HOLD);
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
        end
    end

    // A violation arriving with the clear survives it.
    always_comb begin
        viol_d = viol_q | new_v;
        cnt_d  = cnt_q;
        if (viol_clr) begin
            viol_d = new_v;
            cnt_d  = (new_v != '0) ? ERR_W'(1) : '0;
        end else if ((new_v != '0) && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_q  <= '0;
            viol_q <= '0;
            cnt_q  <= '0;
        end else begin
            tmr_q  <= tmr_d;
            viol_q <= viol_d;
            cnt_q  <= cnt_d;
        end
    end

    assign viol     = viol_q;
    assign viol_cnt = cnt_q;
`else
    localparam int unused_hold = HOLD;
    logic unused_clr;

    assign unused_clr = viol_clr;
    assign viol       = '0;
    assign viol_cnt   = '0;
`endif

endmodule

// File: tb/tb_mitll_ndro_bank.sv
// Scoreboard bench for mitll_ndro_bank: a 4-channel DELAY=2 bank
// plus a 1-channel DELAY=0, ERR_W=2 bank for saturation.
module tb_mitll_ndro_bank;

    localparam int CH = 4;
    localparam int DL = 2;
    localparam int HD = 1;
    localparam int EW = 8;

`ifdef NDRO_VIOL_CHECK_EN
    localparam bit VC = 1'b1;
`else
    localparam bit VC = 1'b0;
`endif

    typedef struct {
        int            due;
        logic [CH-1:0] mask;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [CH-1:0] set_a = '0;
    logic [CH-1:0] rst_a = '0;
    logic          rd_a  = 1'b0;
    logic          clr_a = 1'b0;
    logic [CH-1:0] out_a;
    logic [CH-1:0] st_a;
    logic [CH-1:0] viol_a;
    logic [EW-1:0] cnt_a;

    logic       set_b = 1'b0;
    logic       rst_b = 1'b0;
    logic       rd_b  = 1'b0;
    logic       clr_b = 1'b0;
    logic       out_b;
    logic       st_b;
    logic       viol_b;
    logic [1:0] cnt_b;

    mitll_ndro_bank #(
        .CH(CH), .DELAY(DL), .HOLD(HD), .ERR_W(EW)
    ) dut_a (
        .clk(clk), .reset_n(rst_n),
        .set(set_a), .reset(rst_a), .rd(rd_a),
        .viol_clr(clr_a),
        .out(out_a), .state(st_a),
        .viol(viol_a), .viol_cnt(cnt_a)
    );

    mitll_ndro_bank #(
        .CH(1), .DELAY(0), .HOLD(1), .ERR_W(2)
    ) dut_b (
        .clk(clk), .reset_n(rst_n),
        .set(set_b), .reset(rst_b), .rd(rd_b),
        .viol_clr(clr_b),
        .out(out_b), .state(st_b),
        .viol(viol_b), .viol_cnt(cnt_b)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    ev_t           sb[$];
    logic [CH-1:0] m_st = '0;
    logic [CH-1:0] m_out = '0;
    logic [CH-1:0] m_v = '0;
    logic [EW-1:0] m_c = '0;
    int            m_tmr = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step_a(input logic [CH-1:0] s, input logic [CH-1:0] r,
                          input logic rd, input logic clr);
        logic [CH-1:0] nv;
        ev_t e;
        @(negedge clk);
        set_a = set_a ^ s;
        rst_a = rst_a ^ r;
        rd_a  = rd_a ^ rd;
        clr_a = clr;
        nv = (s & r) | ((s | r) & {CH{rd || (m_tmr != 0)}});
        if (rd) begin
            e.due  = cyc + DL;
            e.mask = m_st;
            sb.push_back(e);
        end
        m_st = (m_st | s) & ~r;
        if (rd) m_tmr = HD;
        else if (m_tmr != 0) m_tmr--;
        if (VC) begin
            if (clr) begin
                m_v = nv;
                m_c = (nv != '0) ? EW'(1) : '0;
            end else begin
                m_v = m_v | nv;
                if (nv != '0 && m_c != '1) m_c = m_c + EW'(1);
            end
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            m_out = m_out ^ e.mask;
        end
        cyc++;
        chk("a_state", st_a, m_st);
        chk("a_out", out_a, m_out);
        chk("a_viol", viol_a, m_v);
        chk("a_cnt", cnt_a, m_c);
    endtask

    task automatic step_b(input logic s, input logic r, input logic rd,
                          input logic e_st, input logic e_out,
                          input logic e_v, input logic [1:0] e_c);
        @(negedge clk);
        set_b = set_b ^ s;
        rst_b = rst_b ^ r;
        rd_b  = rd_b ^ rd;
        @(posedge clk);
        #1;
        chk("b_state", st_b, e_st);
        chk("b_out", out_b, e_out);
        chk("b_viol", viol_b, e_v & VC);
        chk("b_cnt", cnt_b, VC ? e_c : 2'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out"}, {out_a, out_b}, '0);
        chk({tag, "_state"}, {st_a, st_b}, '0);
        chk({tag, "_viol"}, {viol_a, viol_b}, '0);
        chk({tag, "_cnt"}, {cnt_a, cnt_b}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // store 0101, then back-to-back reads
        step_a(4'b0101, 4'b0000, 1'b0, 1'b0);
        step_a(4'b0000, 4'b0000, 1'b0, 1'b0);
        step_a(4'b0000, 4'b0000, 1'b1, 1'b0);
        step_a(4'b0000, 4'b0000, 1'b1, 1'b0);
        repeat (3) step_a(4'b0000, 4'b0000, 1'b0, 1'b0);

        // read coincident with reset of ch0
        step_a(4'b0000, 4'b0001, 1'b1, 1'b0);
        repeat (3) step_a(4'b0000, 4'b0000, 1'b0, 1'b0);

        // set+reset same edge, then clear with a fresh violation
        step_a(4'b0010, 4'b0010, 1'b0, 1'b0);
        step_a(4'b0010, 4'b0010, 1'b0, 1'b1);
        step_a(4'b0000, 4'b0000, 1'b0, 1'b1);
        step_a(4'b0000, 4'b0000, 1'b0, 1'b0);

        // set inside the hold window, then a legal reset
        step_a(4'b0000, 4'b0000, 1'b1, 1'b0);
        step_a(4'b1000, 4'b0000, 1'b0, 1'b0);
        repeat (2) step_a(4'b0000, 4'b0000, 1'b0, 1'b0);
        step_a(4'b0000, 4'b0100, 1'b0, 1'b0);
        repeat (2) step_a(4'b0000, 4'b0000, 1'b0, 1'b0);

        // read in flight when reset asserts
        step_a(4'b0000, 4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        set_a = '0;
        rst_a = '0;
        rd_a  = 1'b0;
        clr_a = 1'b0;
        sb.delete();
        m_st  = '0;
        m_out = '0;
        m_v   = '0;
        m_c   = '0;
        m_tmr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step_a(4'b0000, 4'b0000, 1'b0, 1'b0);
        step_a(4'b0001, 4'b0000, 1'b0, 1'b0);
        repeat (3) step_a(4'b0000, 4'b0000, 1'b0, 1'b0);

        // single channel, DELAY=0
        step_b(1, 0, 0, 1, 0, 0, 2'd0);
        step_b(1, 0, 0, 1, 0, 0, 2'd0);
        step_b(0, 1, 0, 0, 0, 0, 2'd0);
        step_b(0, 1, 0, 0, 0, 0, 2'd0);
        step_b(0, 0, 1, 0, 0, 0, 2'd0);
        step_b(0, 0, 0, 0, 0, 0, 2'd0);
        step_b(1, 0, 0, 1, 0, 0, 2'd0);
        step_b(0, 0, 1, 1, 1, 0, 2'd0);
        step_b(0, 0, 0, 1, 1, 0, 2'd0);
        step_b(0, 0, 0, 1, 1, 0, 2'd0);
        // counter saturation at 3
        step_b(1, 1, 0, 0, 1, 1, 2'd1);
        step_b(1, 1, 0, 0, 1, 1, 2'd2);
        step_b(1, 1, 0, 0, 1, 1, 2'd3);
        step_b(1, 1, 0, 0, 1, 1, 2'd3);
        step_b(1, 1, 0, 0, 1, 1, 2'd3);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
